// File: rtl/uart_rx_if.sv
// Receive-side handshake and status bundle for uart_rx.
interface uart_rx_if;
  logic [7:0] o_data;
  logic       o_valid;
  logic       i_ready;
  logic       o_frame_err;
  logic       o_overrun;
  logic       o_busy;

  modport master (
    output o_data, o_valid, o_frame_err, o_overrun, o_busy,
    input  i_ready
  );

  modport slave (
    input  o_data, o_valid, o_frame_err, o_overrun, o_busy,
    output i_ready
  );
endinterface

// File: rtl/uart_rx.sv
// UART 8N1 receiver: mid-bit sampling of a synchronized rx line, one-deep
// holding register with valid/ready, framing-error and overrun pulses.
module uart_rx #(
  parameter  int unsigned CLKS_PER_BIT = 868,
  localparam int unsigned CNT_W        = $clog2(CLKS_PER_BIT)
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_uart_rx,
  uart_rx_if.master   rx_if
);

  localparam logic [CNT_W-1:0] BIT_END = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] MID_BIT = CNT_W'((CLKS_PER_BIT - 1) / 2);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_e;

  state_e           state_q, state_d;
  logic             rx_meta_q, rx_s_q;
  logic [CNT_W-1:0] clk_cnt_q, clk_cnt_d;
  logic [2:0]       bit_idx_q, bit_idx_d;
  logic [7:0]       shift_q, shift_d;
  logic [7:0]       data_q, data_d;
  logic             valid_q, valid_d;
  logic             ferr_q, ferr_d;
  logic             ovr_q, ovr_d;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
      state_q   <= S_IDLE;
      clk_cnt_q <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      rx_meta_q <= i_uart_rx;
      rx_s_q    <= rx_meta_q;
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (valid_q && rx_if.i_ready) valid_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        clk_cnt_d = '0;
        if (!rx_s_q) state_d = S_START;
      end
      S_START: begin
        if (clk_cnt_q == MID_BIT) begin
          clk_cnt_d = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? S_IDLE : S_DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_DATA: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d          = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == 3'd7) begin
            state_d = S_STOP;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_STOP: begin
        if (clk_cnt_q == BIT_END) begin
          clk_cnt_d = '0;
          if (rx_s_q) begin
            state_d = S_IDLE;
            // A same-cycle accept frees the holding register for the new byte.
            if (!valid_q || rx_if.i_ready) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
          end else begin
            ferr_d  = 1'b1;
            state_d = S_RECOVER;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      S_RECOVER: begin
        clk_cnt_d = '0;
        if (rx_s_q) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rx_if.o_data      = data_q;
  assign rx_if.o_valid     = valid_q;
  assign rx_if.o_frame_err = ferr_q;
  assign rx_if.o_overrun   = ovr_q;
  assign rx_if.o_busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed scenarios plus random frames against an
// abstract holding-register model (full/empty, byte, expected pulses).
module tb_uart_rx;
  localparam int unsigned CPB = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rx  = 1'b1;

  uart_rx_if bus ();

  uart_rx #(.CLKS_PER_BIT(CPB)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_uart_rx (rx),
    .rx_if     (bus.master)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Monitor: deliveries and pulse counts as seen by a consumer
  logic [7:0]  deliv_q[$];
  int unsigned ferr_cnt = 0, ovr_cnt = 0, pulse_viol = 0;
  logic        ferr_prev = 1'b0, ovr_prev = 1'b0;

  always @(posedge clk) begin
    if (!rst) begin
      if (bus.o_valid && bus.i_ready) deliv_q.push_back(bus.o_data);
      if (bus.o_frame_err) ferr_cnt++;
      if (bus.o_overrun)   ovr_cnt++;
      if ((ferr_prev && bus.o_frame_err) || (ovr_prev && bus.o_overrun)) pulse_viol++;
    end
    ferr_prev <= bus.o_frame_err;
    ovr_prev  <= bus.o_overrun;
  end

  // Reference model: holding register as an abstract full/empty slot
  logic [7:0]  exp_q[$];
  logic        m_full = 1'b0;
  logic [7:0]  m_data = 8'h00;
  int unsigned exp_ferr = 0, exp_ovr = 0;

  task automatic model_frame(input logic [7:0] b, input bit good);
    if (!good)       exp_ferr++;
    else if (m_full) exp_ovr++;
    else begin
      m_full = 1'b1;
      m_data = b;
    end
  endtask

  task automatic model_accept();
    if (m_full) begin
      exp_q.push_back(m_data);
      m_full = 1'b0;
    end
  endtask

  task automatic cycles(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  // Drives start, 8 data bits LSB first, one stop bit; line stays at stop level
  task automatic send_frame(input logic [7:0] b, input bit stop);
    rx = 1'b0;
    cycles(CPB);
    for (int unsigned i = 0; i < 8; i++) begin
      rx = b[i];
      cycles(CPB);
    end
    rx = stop;
    cycles(CPB);
  endtask

  task automatic pulse_ready();
    bus.i_ready = 1'b1;
    @(negedge clk);
    bus.i_ready = 1'b0;
  endtask

  int unsigned lat;
  int unsigned busy_cycles;
  bit          seen_valid, seen_ferr, busy_at_rise;

  initial begin
    bus.i_ready = 1'b0;
    cycles(3);
    check("rst_data",  bus.o_data, 32'h00);
    check("rst_valid", bus.o_valid, 0);
    check("rst_ferr",  bus.o_frame_err, 0);
    check("rst_ovr",   bus.o_overrun, 0);
    check("rst_busy",  bus.o_busy, 0);
    rst = 1'b0;
    cycles(4);

    // Basic byte with latency measurement from the falling edge
    lat = 0;
    busy_at_rise = 1'b1;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        while (!bus.o_valid && lat < 400) begin
          @(negedge clk);
          lat++;
        end
        busy_at_rise = bus.o_busy;
      end
    join
    model_frame(8'hA5, 1'b1);
    check("basic_lat_ok", (lat >= 154 && lat <= 156), 1);
    check("basic_data", bus.o_data, 32'hA5);
    check("basic_busy_at_valid", busy_at_rise, 0);
    check("basic_ferr_cnt", ferr_cnt, 0);
    pulse_ready();
    model_accept();
    check("basic_valid_clear", bus.o_valid, 0);
    cycles(4);

    // Back-to-back frames, consumer accepts one cycle after each valid
    fork
      begin
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
      end
      begin
        for (int k = 0; k < 2; k++) begin
          int unsigned t = 0;
          while (!bus.o_valid && t < 400) begin
            @(negedge clk);
            t++;
          end
          check("b2b_wait", (t < 400), 1);
          @(negedge clk);
          pulse_ready();
        end
      end
    join
    exp_q.push_back(8'h00);
    exp_q.push_back(8'hFF);
    check("b2b_ovr_cnt", ovr_cnt, exp_ovr);
    cycles(4);

    // Overrun: second byte dropped while holding register is full
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    model_frame(8'hC3, 1'b1);
    cycles(2);
    check("ovr_data", bus.o_data, 32'h3C);
    check("ovr_valid", bus.o_valid, 1);
    check("ovr_cnt", ovr_cnt, exp_ovr);
    pulse_ready();
    model_accept();
    check("ovr_valid_clear", bus.o_valid, 0);
    cycles(4);

    // Framing error followed by a long break
    send_frame(8'h55, 1'b0);
    model_frame(8'h55, 1'b0);
    cycles(40 * CPB);
    check("break_ferr_cnt", ferr_cnt, exp_ferr);
    check("break_valid", bus.o_valid, 0);
    check("break_busy", bus.o_busy, 1);
    rx = 1'b1;
    cycles(4);
    check("break_idle", bus.o_busy, 0);
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    cycles(2);
    check("after_break_data", bus.o_data, 32'h81);
    check("after_break_valid", bus.o_valid, 1);

    // Glitch on the idle line: 0x81 stays held, busy briefly
    busy_cycles = 0;
    seen_ferr   = 1'b0;
    rx = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (i == 5) rx = 1'b1;
      @(negedge clk);
      if (bus.o_busy) busy_cycles++;
      if (bus.o_frame_err) seen_ferr = 1'b1;
    end
    check("glitch_busy_ok", (busy_cycles >= 1 && busy_cycles <= 10), 1);
    check("glitch_ferr", seen_ferr, 0);
    check("glitch_busy_end", bus.o_busy, 0);
    check("glitch_data", bus.o_data, 32'h81);

    // Async reset in data bit 4 of 0x96; held byte 0x81 is also discarded
    fork
      send_frame(8'h96, 1'b1);
      begin
        cycles(CPB * 5 + CPB / 2);
        #2 rst = 1'b1;
        #1;
        check("arst_valid", bus.o_valid, 0);
        check("arst_busy", bus.o_busy, 0);
        check("arst_data", bus.o_data, 32'h00);
      end
    join
    m_full = 1'b0;
    cycles(3);
    rst = 1'b0;
    cycles(4);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    cycles(2);
    check("post_rst_data", bus.o_data, 32'h5A);
    pulse_ready();
    model_accept();
    cycles(4);

    // Random frames: random bytes, occasional bad stop, random consumer
    for (int n = 0; n < 24; n++) begin
      logic [7:0] b;
      bit         good;
      b    = 8'($urandom);
      good = ($urandom_range(0, 5) != 0);
      send_frame(b, good);
      model_frame(b, good);
      if (!good) begin
        cycles($urandom_range(0, 3 * CPB));
        rx = 1'b1;
      end
      cycles($urandom_range(2, 6));
      check("rnd_valid", bus.o_valid, m_full);
      if (m_full) check("rnd_data", bus.o_data, m_data);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ready();
        model_accept();
      end
      cycles($urandom_range(0, 8));
    end
    cycles(4);

    check("ferr_total", ferr_cnt, exp_ferr);
    check("ovr_total", ovr_cnt, exp_ovr);
    check("pulse_width", pulse_viol, 0);
    check("deliv_count", deliv_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < deliv_q.size(); i++)
      check("deliv_byte", deliv_q[i], exp_q[i]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #20_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
UART 8N1 receiver. It is the receive-direction counterpart of the existing uart_tx inside the UART IP.
- Oversamples the asynchronous rx pin and delivers each byte through a one-deep holding register with a valid/ready handshake.
- Flags framing errors and overruns for the CSR block, which exposes them as status bits.

Parameters:
CLKS_PER_BIT, 868, i_clk cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
CNT_W, $clog2(CLKS_PER_BIT), width of the baud counter; derived, never overridden.

Ports:
i_clk  input  1  system clock; all logic on rising edge.
i_rst  input  1  asynchronous, active-high reset.
i_uart_rx  input  1  raw serial line; idle high; asynchronous to i_clk.
o_data  output  8  last received byte; stable while o_valid=1.
o_valid  output  1  holding register full.
i_ready  input  1  consumer accepts o_data when o_valid & i_ready.
o_frame_err  output  1  one-cycle pulse when a stop bit is sampled low.
o_overrun  output  1  one-cycle pulse when a good byte is dropped because the holding register is full.
o_busy  output  1  high in any state other than IDLE.

Behaviour:
- Reset, asynchronous, active-high. Every flop takes its reset value immediately:
  - Synchronizer flops = 1; state = IDLE; counters = 0; shift register = 0.
  - o_data = 0x00; o_valid = 0; o_frame_err = 0; o_overrun = 0; o_busy = 0.
- Reset asserted mid-frame aborts the frame; no partial byte is ever delivered.
- Input path: 2-flop synchronizer i_uart_rx -> rx_s. The FSM uses only rx_s, which adds 2 cycles of latency.
- States: IDLE, START, DATA, STOP, RECOVER.
- IDLE:
  - rx_s=0 -> START with clk_cnt=0.
- START:
  - Counts clk_cnt up to (CLKS_PER_BIT-1)/2 (integer division), i.e. the mid-bit point.
  - At the mid-bit point, rx_s=0 -> DATA with clk_cnt=0, bit_idx=0.
  - At the mid-bit point, rx_s=1 -> IDLE. This is a glitch reject: no flag, no pulse.
- DATA:
  - When clk_cnt = CLKS_PER_BIT-1: sample rx_s into shift[bit_idx] (LSB first), clk_cnt=0, bit_idx+1.
  - After the sample with bit_idx=7 -> STOP. bit_idx is 3 bits; no wrap beyond 7.
- STOP:
  - When clk_cnt = CLKS_PER_BIT-1: sample rx_s.
  - rx_s=1 -> byte complete -> IDLE on the same edge. This allows back-to-back frames with a single stop bit.
  - rx_s=0 -> o_frame_err=1 for one cycle; byte discarded -> RECOVER.
- RECOVER:
  - Waits for rx_s=1, then -> IDLE. This means a break condition, or a line held low, yields exactly one frame error.
- Byte completion, handled on the edge the good stop bit is sampled:
  - o_valid=0, or o_valid=1 with i_ready=1 in the same cycle: o_data <= shift, o_valid <= 1, no overrun.
  - o_valid=1 with i_ready=0: o_data is kept, the new byte is dropped, and o_overrun=1 for one cycle.
- Handshake:
  - o_valid stays high until a cycle with i_ready=1. It clears on the following edge unless a new byte loads on that same edge.
  - i_ready with o_valid=0 is ignored.
- Latency: falling edge on i_uart_rx to o_valid rise = 2 (sync) + 1 (IDLE detect) + (CLKS_PER_BIT-1)/2 + 1 + 9*CLKS_PER_BIT cycles, ±1.
- Counter width: clk_cnt is CNT_W bits and never exceeds CLKS_PER_BIT-1.
- Pulse rule: o_frame_err and o_overrun are registered and are never high for two consecutive cycles from a single event.

Test Plan:
- Basic byte: CLKS_PER_BIT=16, i_ready=0. Drive 0xA5 8N1 (start, 1,0,1,0,0,1,0,1, stop).
  -> o_valid rises 155±1 cycles after the falling edge; o_data=0xA5; o_frame_err=0; o_busy falls on the same edge.
- Back-to-back with handshake: 0x00 then 0xFF, one stop bit, no gap. i_ready pulsed 1 cycle after each o_valid.
  -> two deliveries, 0x00 then 0xFF; no overrun.
- Overrun: 0x3C then 0xC3 with i_ready held 0.
  -> o_data stays 0x3C; o_overrun pulses once at the second stop sample; o_valid stays 1.
  -> Asserting i_ready then clears o_valid the next cycle.
- Framing error/break: start, data 0x55, stop driven low, line held low for 40 bit times.
  -> exactly one o_frame_err pulse; o_valid stays 0; FSM stays in RECOVER until the line goes high.
  -> A following 0x81 is received correctly.
- Glitch: low pulse of 5 cycles (less than CLKS_PER_BIT/2) on the idle line.
  -> returns to IDLE; no o_valid, no o_frame_err; o_busy high for at most 10 cycles.
- Async reset mid-frame: assert i_rst during DATA bit 4 of 0x96, then release and send 0x5A.
  -> o_valid=0 and o_busy=0 immediately when i_rst rises; only 0x5A is delivered.
